// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline stages, the shared memory port arbiter and
// the memory macro.
//   master : pipeline/memory side (drives requests and ram_rdata)
//   slave  : arbiter side (drives completions, stalls and the ram strobes)
// Signals:
//   if_req/if_addr -> fetch request        if_rdata/if_valid/if_stall <- fetch result
//   mem_req/mem_we/mem_addr/mem_wdata      mem_rdata/mem_valid/mem_stall
//   ram_en/ram_we/ram_addr/ram_wdata       ram_rdata (memory read data)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              mem_stall;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
        output ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter.
// Serialises IF fetches and MEM loads/stores onto one memory port with a fixed
// read latency LAT (cycles from the ram_en cycle to valid ram_rdata).
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   run  - grant enable; low blocks new grants, in-flight access completes
//   bus  - slave view of mem_port_arbiter_if (requests, completions, stalls,
//          registered ram strobes and ram_rdata)
// Each access: grant edge -> ram_en cycle (cnt=0) -> LAT cycles -> valid cycle.
// The valid cycle is also the next IDLE sampling cycle.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BUSY_IF  = 2'd1;
    localparam logic [1:0] ST_BUSY_MEM = 2'd2;

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              last_mem_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] mem_rdata_reg;
    logic              if_valid_reg;
    logic              mem_valid_reg;
    logic              ram_en_reg;
    logic              ram_we_reg;

    logic grant_mem;
    logic grant_if;

    // On contention MEM wins unless it also won last time, so the two
    // requesters alternate and neither starves.
    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (state_reg == ST_IDLE && run) begin
            if (bus.mem_req && !(bus.if_req && last_mem_reg)) begin
                grant_mem = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            last_mem_reg  <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            if_valid_reg  <= 1'b0;
            mem_valid_reg <= 1'b0;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
        end else begin
            // Pulses and strobes last exactly one cycle.
            if_valid_reg  <= 1'b0;
            mem_valid_reg <= 1'b0;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_mem) begin
                        state_reg    <= ST_BUSY_MEM;
                        addr_reg     <= bus.mem_addr;
                        we_reg       <= bus.mem_we;
                        wdata_reg    <= bus.mem_wdata;
                        cnt_reg      <= '0;
                        last_mem_reg <= 1'b1;
                        ram_en_reg   <= 1'b1;
                        ram_we_reg   <= bus.mem_we;
                    end else if (grant_if) begin
                        state_reg    <= ST_BUSY_IF;
                        addr_reg     <= bus.if_addr;
                        we_reg       <= 1'b0;
                        cnt_reg      <= '0;
                        last_mem_reg <= 1'b0;
                        ram_en_reg   <= 1'b1;
                    end
                end
                ST_BUSY_IF, ST_BUSY_MEM: begin
                    if (cnt_reg == LAT_CNT) begin
                        state_reg <= ST_IDLE;
                        if (state_reg == ST_BUSY_IF) begin
                            if_rdata_reg <= bus.ram_rdata;
                            if_valid_reg <= 1'b1;
                        end else begin
                            // Stores complete without touching the load data.
                            mem_valid_reg <= 1'b1;
                            if (!we_reg) begin
                                mem_rdata_reg <= bus.ram_rdata;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_en    = ram_en_reg;
    assign bus.ram_we    = ram_we_reg;
    assign bus.ram_addr  = addr_reg;
    assign bus.ram_wdata = wdata_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.if_valid  = if_valid_reg;
    assign bus.mem_rdata = mem_rdata_reg;
    assign bus.mem_valid = mem_valid_reg;
    assign bus.if_stall  = bus.if_req & ~if_valid_reg;
    assign bus.mem_stall = bus.mem_req & ~mem_valid_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NI = 4;   // instances with LAT = 1..4

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, run, sweep;
    logic          if_req_d, mem_req_d, mem_we_d;
    logic [AW-1:0] if_addr_d, mem_addr_d;
    logic [DW-1:0] mem_wdata_d;

    int edge_n   = 0;
    int n_checks = 0;
    int n_fail   = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    logic [NI-1:0]         ram_en_v, ram_we_v, if_valid_v, mem_valid_v;
    logic [NI-1:0]         if_stall_v, mem_stall_v, sweep_done;
    logic [NI-1:0][AW-1:0] ram_addr_v;
    logic [NI-1:0][DW-1:0] ram_wdata_v, if_rdata_v, mem_rdata_v;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LAT = gi + 1;

        mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .run (run),
            .bus (bus)
        );

        // Sweep mode: a little PC that advances on each fetch completion,
        // presenting the next address already in the valid cycle.
        logic [AW-1:0] pc;
        logic [AW-1:0] fetch_addr;
        assign fetch_addr    = pc + {{(AW-1){1'b0}}, bus.if_valid};
        assign bus.if_req    = sweep ? (fetch_addr < 8) : if_req_d;
        assign bus.if_addr   = sweep ? fetch_addr : if_addr_d;
        assign bus.mem_req   = sweep ? 1'b0 : mem_req_d;
        assign bus.mem_we    = mem_we_d;
        assign bus.mem_addr  = mem_addr_d;
        assign bus.mem_wdata = mem_wdata_d;
        assign sweep_done[gi] = (pc == 8);

        // Memory macro: data appears exactly LAT cycles after the ram_en
        // cycle; any other cycle shows a poison value.
        logic [DW-1:0] ram [0:255];
        logic [DW-1:0] rd_pipe [0:LAT-1];
        initial for (int i = 0; i < 256; i++) ram[i] = 32'hDEAD0000 | i;
        assign bus.ram_rdata = rd_pipe[LAT-1];
        always @(posedge clk) begin
            rd_pipe[0] <= (bus.ram_en && !bus.ram_we) ? ram[bus.ram_addr[7:0]] : 32'hBAD0BAD0;
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
            if (bus.ram_en && bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
            if (!sweep) pc <= '0;
            else if (bus.if_valid) pc <= pc + 1;
        end

        assign ram_en_v[gi]    = bus.ram_en;
        assign ram_we_v[gi]    = bus.ram_we;
        assign ram_addr_v[gi]  = bus.ram_addr;
        assign ram_wdata_v[gi] = bus.ram_wdata;
        assign if_rdata_v[gi]  = bus.if_rdata;
        assign mem_rdata_v[gi] = bus.mem_rdata;
        assign if_valid_v[gi]  = bus.if_valid;
        assign mem_valid_v[gi] = bus.mem_valid;
        assign if_stall_v[gi]  = bus.if_stall;
        assign mem_stall_v[gi] = bus.mem_stall;

        // Transaction-level model: one outstanding access stamped with its
        // grant edge; ram_en one cycle after, completion LAT+1 edges after.
        logic          m_busy, m_is_mem, m_we, m_last, m_if_v, m_mem_v;
        int            m_grant;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_if_data, m_mem_data;
        logic [DW-1:0] shadow [0:255];
        initial for (int i = 0; i < 256; i++) shadow[i] = 32'hDEAD0000 | i;
        wire m_pick_mem = bus.mem_req & ~(bus.if_req & m_last);

        always @(posedge clk) begin
            if (rst) begin
                m_busy <= 1'b0; m_last <= 1'b0; m_we <= 1'b0; m_is_mem <= 1'b0;
                m_addr <= '0; m_wdata <= '0; m_if_data <= '0; m_mem_data <= '0;
                m_if_v <= 1'b0; m_mem_v <= 1'b0; m_grant <= 0;
            end else begin
                m_if_v  <= 1'b0;
                m_mem_v <= 1'b0;
                if (m_busy) begin
                    if (edge_n == m_grant + LAT + 1) begin
                        m_busy <= 1'b0;
                        if (!m_is_mem) begin
                            m_if_v    <= 1'b1;
                            m_if_data <= shadow[m_addr[7:0]];
                        end else begin
                            m_mem_v <= 1'b1;
                            if (m_we) shadow[m_addr[7:0]] <= m_wdata;
                            else      m_mem_data <= shadow[m_addr[7:0]];
                        end
                    end
                end else if (run && (bus.if_req || bus.mem_req)) begin
                    m_busy   <= 1'b1;
                    m_grant  <= edge_n;
                    m_is_mem <= m_pick_mem;
                    m_last   <= m_pick_mem;
                    if (m_pick_mem) begin
                        m_addr  <= bus.mem_addr;
                        m_we    <= bus.mem_we;
                        m_wdata <= bus.mem_wdata;
                    end else begin
                        m_addr <= bus.if_addr;
                        m_we   <= 1'b0;
                    end
                end
            end
        end

        wire exp_ram_en = m_busy && (edge_n == m_grant + 1);

        always @(negedge clk) begin
            if (edge_n > 0) begin
                check($sformatf("lat%0d ram_en", LAT),    bus.ram_en,    exp_ram_en);
                check($sformatf("lat%0d ram_we", LAT),    bus.ram_we,    exp_ram_en & m_we);
                check($sformatf("lat%0d ram_addr", LAT),  bus.ram_addr,  m_addr);
                check($sformatf("lat%0d ram_wdata", LAT), bus.ram_wdata, m_wdata);
                check($sformatf("lat%0d if_valid", LAT),  bus.if_valid,  m_if_v);
                check($sformatf("lat%0d mem_valid", LAT), bus.mem_valid, m_mem_v);
                check($sformatf("lat%0d if_rdata", LAT),  bus.if_rdata,  m_if_data);
                check($sformatf("lat%0d mem_rdata", LAT), bus.mem_rdata, m_mem_data);
                check($sformatf("lat%0d if_stall", LAT),  bus.if_stall,  bus.if_req & ~m_if_v);
                check($sformatf("lat%0d mem_stall", LAT), bus.mem_stall, bus.mem_req & ~m_mem_v);
            end
        end

        // Sweep: data in address order, completions exactly LAT+2 apart.
        int last_v = 0;
        always @(negedge clk) begin
            if (sweep && bus.if_valid) begin
                check($sformatf("lat%0d sweep data", LAT), bus.if_rdata, 32'hDEAD0000 + pc);
                if (pc != 0) check($sformatf("lat%0d sweep spacing", LAT), edge_n - last_v, LAT + 2);
                last_v <= edge_n;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; sweep = 1'b0;
        if_req_d = 1'b0; mem_req_d = 1'b0; mem_we_d = 1'b0;
        if_addr_d = '0; mem_addr_d = '0; mem_wdata_d = '0;
        tick(); tick();
        check("reset ram_en", ram_en_v, 4'h0);
        check("reset if_valid", if_valid_v, 4'h0);
        check("reset mem_valid", mem_valid_v, 4'h0);
        check("reset ram_addr", ram_addr_v[0], 32'h0);
        check("reset if_rdata", if_rdata_v[0], 32'h0);
        check("reset mem_rdata", mem_rdata_v[0], 32'h0);
        $display("txn reset done");

        // Single fetch, LAT=1
        rst = 1'b0; run = 1'b1; if_addr_d = 32'h5; if_req_d = 1'b1;
        tick();
        check("fetch ram_en", ram_en_v[0], 1'b1);
        check("fetch ram_addr", ram_addr_v[0], 32'h5);
        check("fetch ram_we", ram_we_v[0], 1'b0);
        check("fetch stall c1", if_stall_v[0], 1'b1);
        tick();
        check("fetch ram_en off", ram_en_v[0], 1'b0);
        check("fetch stall c2", if_stall_v[0], 1'b1);
        check("fetch no early valid", if_valid_v[0], 1'b0);
        tick();
        check("fetch valid", if_valid_v[0], 1'b1);
        check("fetch data", if_rdata_v[0], 32'hDEAD0005);
        check("fetch stall low", if_stall_v[0], 1'b0);
        if_req_d = 1'b0;
        tick();
        check("fetch valid pulse", if_valid_v[0], 1'b0);
        check("fetch data held", if_rdata_v[0], 32'hDEAD0005);
        $display("txn fetch addr=5 data=%h", if_rdata_v[0]);
        repeat (8) tick();

        // Contention: MEM, IF, MEM, IF
        if_addr_d = 32'h20; mem_addr_d = 32'h30; if_req_d = 1'b1; mem_req_d = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("contend ram_en", ram_en_v[0], (k % 3) == 0);
            if ((k % 3) == 0)
                check("contend order", ram_addr_v[0], ((k / 3) % 2 == 0) ? 32'h30 : 32'h20);
        end
        check("contend if_rdata", if_rdata_v[0], 32'hDEAD0020);
        check("contend mem_rdata", mem_rdata_v[0], 32'hDEAD0030);
        if_req_d = 1'b0; mem_req_d = 1'b0;
        $display("txn contention 4 accesses");
        repeat (8) tick();

        // Store then load back
        mem_req_d = 1'b1; mem_we_d = 1'b1; mem_addr_d = 32'h10; mem_wdata_d = 32'h12345678;
        tick();
        check("store ram_en", ram_en_v[0], 1'b1);
        check("store ram_we", ram_we_v[0], 1'b1);
        check("store ram_wdata", ram_wdata_v[0], 32'h12345678);
        check("store ram_addr", ram_addr_v[0], 32'h10);
        tick();
        check("store ram_we off", ram_we_v[0], 1'b0);
        check("store wdata held", ram_wdata_v[0], 32'h12345678);
        tick();
        check("store valid", mem_valid_v[0], 1'b1);
        check("store rdata kept", mem_rdata_v[0], 32'hDEAD0030);
        mem_req_d = 1'b0; mem_we_d = 1'b0;
        $display("txn store addr=10 data=12345678");
        repeat (8) tick();
        mem_req_d = 1'b1;
        tick(); tick(); tick();
        check("load-back valid", mem_valid_v[0], 1'b1);
        check("load-back data", mem_rdata_v[0], 32'h12345678);
        mem_req_d = 1'b0;
        $display("txn load addr=10 data=%h", mem_rdata_v[0]);
        repeat (8) tick();

        // run gating
        run = 1'b0; if_req_d = 1'b1; if_addr_d = 32'h7;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("gated no ram_en", ram_en_v, 4'h0);
            check("gated if_stall", if_stall_v[0], 1'b1);
        end
        if_req_d = 1'b0; mem_req_d = 1'b1; mem_addr_d = 32'h11; run = 1'b1;
        tick();
        check("run-drop grant", ram_en_v[0], 1'b1);
        run = 1'b0;
        tick(); tick();
        check("run-drop completes", mem_valid_v[0], 1'b1);
        check("run-drop data", mem_rdata_v[0], 32'hDEAD0011);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("run-drop no grant", ram_en_v, 4'h0);
            check("run-drop mem_stall", mem_stall_v[0], 1'b1);
        end
        mem_req_d = 1'b0; run = 1'b1;
        $display("txn run gating");
        repeat (8) tick();

        // Reset mid-access (LAT=3 instance at cnt=1)
        if_req_d = 1'b1; if_addr_d = 32'h40;
        tick();
        check("rst-mid grant", ram_en_v[2], 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check("rst-mid ram_en", ram_en_v, 4'h0);
        check("rst-mid if_valid", if_valid_v, 4'h0);
        check("rst-mid ram_addr", ram_addr_v[2], 32'h0);
        check("rst-mid ram_wdata", ram_wdata_v[2], 32'h0);
        check("rst-mid if_rdata", if_rdata_v[2], 32'h0);
        check("rst-mid mem_rdata", mem_rdata_v[2], 32'h0);
        rst = 1'b0; mem_req_d = 1'b1; mem_addr_d = 32'h41;
        tick();
        check("post-rst mem first", ram_en_v[2], 1'b1);
        check("post-rst mem addr", ram_addr_v[2], 32'h41);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post-rst no early valid", mem_valid_v[2] | if_valid_v[2], 1'b0);
        end
        tick();
        check("post-rst mem valid", mem_valid_v[2], 1'b1);
        check("post-rst mem data", mem_rdata_v[2], 32'hDEAD0041);
        if_req_d = 1'b0; mem_req_d = 1'b0;
        $display("txn reset mid-access");
        repeat (8) tick();

        // LAT sweep: back-to-back fetches of 0..7 in every instance
        sweep = 1'b1;
        for (int k = 0; k < 100 && sweep_done != 4'hF; k++) tick();
        check("sweep all done", sweep_done, 4'hF);
        sweep = 1'b0;
        $display("txn lat sweep done=%b", sweep_done);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared instruction/data memory port between the IF-stage fetch and the MEM-stage load/store. It serialises accesses through a small FSM with a fixed memory read latency. It returns data with a one-cycle valid pulse and generates per-requester stall signals for the pipeline. Placement: between the pipeline stages and the memory macro, replacing direct stage-to-memory wiring.

## Interface
Parameters:
- ADDR_W, 32, address width (word addresses; PC increments by 1)
- DATA_W, 32, data width
- LAT, 1, memory read latency in cycles from the ram_en cycle to ram_rdata valid; legal range LAT ≥ 1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  grant enable (start switch); low = no new grants
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, held until next IF completion
- if_valid  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_valid (combinational)
- mem_req  in  1  data request, level
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address (ALU result)
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, held until next MEM completion
- mem_valid  out  1  one-cycle completion pulse for load or store
- mem_stall  out  1  mem_req & ~mem_valid (combinational)
- ram_en  out  1  memory access strobe, registered
- ram_we  out  1  memory write strobe, registered, only with ram_en
- ram_addr  out  ADDR_W  memory address, registered
- ram_wdata  out  DATA_W  memory write data, registered
- ram_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM. Counter cnt, width $clog2(LAT+1). Flag last_mem records whether the last grant went to MEM.
- In IDLE at a rising edge with run=1, grants are decided as follows:
  - mem_req only: grant MEM.
  - if_req only: grant IF.
  - Both requests: grant MEM unless last_mem=1, in which case grant IF. This alternates on contention so neither requester starves.
  - No request, or run=0: stay in IDLE.
- On grant:
  - Latch the address, and for MEM also we and wdata. An IF grant forces we=0.
  - cnt<=0. Update last_mem.
- BUSY_x:
  - ram_en=1 only in the cycle with cnt==0. ram_we=latched we in that cycle, otherwise 0. ram_addr/ram_wdata hold the latched values for the whole access.
  - cnt increments each cycle.
  - In the cycle with cnt==LAT, at the ending edge: the x_rdata register <= ram_rdata (loads and fetches only; stores leave mem_rdata unchanged), x_valid<=1 for one cycle, state<=IDLE.
- Requests are levels. The requester's req value during its valid cycle is sampled as a new request. Holding req high therefore gives back-to-back accesses.
- run deasserted mid-access: the in-flight access completes normally. No further grants are made.
- Request inputs (addr, we, wdata) are ignored outside the grant edge.
- The arbiter never drives ram_en for two requesters simultaneously. At most one access is outstanding.

## Timing
- Reset values: state=IDLE, cnt=0, last_mem=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0, if_valid=0, mem_valid=0.
- Reset asserted mid-access: the access is dropped, no valid pulse is produced, and all outputs take their reset values at the next edge.
- Latency from a sampled req to the valid cycle is LAT+2 cycles:
  - grant edge → ram_en cycle (cnt=0) → LAT cycles → valid cycle.
  - Example with LAT=1: req sampled at edge 0; ram_en in cycle 1; capture at the edge ending cycle 2; valid in cycle 3.
- Sustained throughput for one requester holding req: one access per LAT+2 cycles. The valid cycle doubles as the next IDLE sampling cycle.
- Stall outputs are combinational. A stall is high from req assertion through the cycle before valid, and low in the valid cycle.

## Test plan
- Reset then single fetch, LAT=1: rst 1→0, if_addr=0x5, if_req held one access. Expect ram_en=1 with ram_addr=5, ram_we=0 exactly 1 cycle; ram_rdata=0xDEAD0005 → if_rdata=0xDEAD0005, if_valid pulse 3 cycles after the grant edge; if_stall high until that cycle.
- Contention alternation: if_req=mem_req=1 held continuously, run=1. Expect grant order MEM, IF, MEM, IF…, one access per LAT+2 cycles, and never two ram_en in the same access.
- Store: mem_req=1, mem_we=1, mem_addr=0x10, mem_wdata=0x12345678. Expect ram_we=1 only in the ram_en cycle with ram_wdata=0x12345678; mem_valid pulse; mem_rdata unchanged.
- run gating: run=0 with if_req=1 → no ram_en, if_stall=1 indefinitely. Drop run during BUSY_MEM → the current access still completes with mem_valid, then no further grants.
- Reset mid-access, LAT=3: rst pulsed while cnt=1. Expect no valid pulse, all outputs 0 next cycle, and the next request served normally from IDLE with MEM priority (last_mem=0).
- LAT sweep 1..4: back-to-back fetches of addresses 0..7. Expect data in order, spacing exactly LAT+2 cycles.
